uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 67 ++++++
 tb/tb_uart_tx_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter with packet lock feeding one shared UART transmitter
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int LOCK_TIMEOUT = 1023
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx_start,
   output logic [7:0]                 tx_data,
   input  logic                       tx_busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       locked
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} stateType;
   stateType state, stateNext;
   logic [15:0] lockCnt;
   logic [IW-1:0] rrSel, rrIdx, acceptId;
   logic rrFound, accept;
   // first valid port scanning upward from grant_id+1 with wrap to port 0
   always_comb begin
      rrSel = grant_id;
      rrIdx = grant_id;
      rrFound = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         rrIdx = (rrIdx == IW'(NUM_REQ - 1)) ? '0 : rrIdx + IW'(1);
         if (!rrFound && req_valid[rrIdx]) begin
            rrSel = rrIdx;
            rrFound = 1'b1;
         end
      end
   end
   // accept decision and next state; a held lock only lets the owning port through
   always_comb begin
      acceptId = locked ? grant_id : rrSel;
      accept = !rst && state == IDLE && !tx_busy && (locked ? req_valid[grant_id] : rrFound);
      req_ready = accept ? NUM_REQ'(1) << acceptId : '0;
      tx_start = state == LAUNCH;
      stateNext = state == IDLE ? (accept ? LAUNCH : IDLE) :
                  state == LAUNCH ? WAIT : (tx_busy ? WAIT : IDLE);
   end
   // state, latched byte, grant and lock-timeout registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         tx_data <= 8'h00;
         grant_id <= IW'(NUM_REQ - 1);
         locked <= 1'b0;
         lockCnt <= '0;
      end else begin
         state <= stateNext;
         if (accept) begin
            tx_data <= req_data[{acceptId, 3'b000} +: 8];
            grant_id <= acceptId;
            locked <= !req_last[acceptId];
            lockCnt <= '0;
         end else if (state == IDLE && locked && !tx_busy) begin
            locked <= lockCnt != 16'(LOCK_TIMEOUT - 1);
            lockCnt <= lockCnt == 16'(LOCK_TIMEOUT - 1) ? '0 : lockCnt + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for the UART transmit arbiter with a simple transmitter model
module tb_uart_tx_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] reqValid, reqLast, reqReady;
   logic [31:0] reqData;
   logic txStart, txBusy, locked;
   logic [7:0] txData;
   logic [1:0] grantId;
   logic [3:0] busyCnt = '0;
   logic [8:0] portMem [4][16];
   int head [4];
   int tail [4];
   int checks = 0;
   int passes = 0;
   typedef struct packed {logic [1:0] g; logic [7:0] d; logic lk;} expType;
   expType expQ [$];

   uart_tx_arbiter #(.NUM_REQ(4), .LOCK_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .req_valid(reqValid), .req_data(reqData), .req_last(reqLast),
      .req_ready(reqReady), .tx_start(txStart), .tx_data(txData), .tx_busy(txBusy),
      .grant_id(grantId), .locked(locked)
   );

   // clock
   always #5 clk = ~clk;

   // transmitter model: busy with the start pulse and for four cycles after it
   assign txBusy = txStart || busyCnt != 0;
   always @(posedge clk) busyCnt <= txStart ? 4'd4 : (busyCnt != 0 ? busyCnt - 4'd1 : 4'd0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic sendByte(input int p, input logic last, input logic [7:0] d);
      portMem[p][tail[p]] = {last, d};
      tail[p]++;
   endtask

   task automatic expectByte(input logic [1:0] g, input logic [7:0] d, input logic lk);
      expQ.push_back('{g: g, d: d, lk: lk});
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      $display("FAIL %s: bound expired, got no event expected one at %0t", name, $time);
   endtask

   task automatic drain();
      int n = 0;
      while ((expQ.size() != 0 || head[0] != tail[0] || head[1] != tail[1] ||
              head[2] != tail[2] || head[3] != tail[3]) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) timeoutFail("drain");
      repeat (8) @(negedge clk);
   endtask

   // port driver: holds each port's head byte until the arbiter accepts it
   initial begin
      logic [3:0] acc;
      for (int p = 0; p < 4; p++) begin
         head[p] = 0;
         tail[p] = 0;
      end
      reqValid = '0;
      reqLast = '0;
      reqData = '0;
      forever begin
         @(negedge clk);
         acc = reqValid & reqReady;
         @(posedge clk);
         #1;
         for (int p = 0; p < 4; p++) begin
            if (acc[p]) head[p]++;
            reqValid[p] = head[p] != tail[p];
            reqLast[p] = reqValid[p] ? portMem[p][head[p]][8] : 1'b0;
            reqData[8*p +: 8] = reqValid[p] ? portMem[p][head[p]][7:0] : 8'h00;
         end
      end
   end

   // monitor: protocol checks every cycle and scoreboard pop on each start pulse
   initial begin
      logic accPrev = 1'b0;
      logic startPrev = 1'b0;
      expType e;
      forever begin
         @(negedge clk);
         if (reqReady != 0) begin
            check("ready_onehot", $countones(reqReady), 1);
            check("ready_while_busy", txBusy, 0);
         end
         if (accPrev || txStart) check("start_latency", txStart, accPrev);
         if (txStart) begin
            check("start_width", startPrev, 0);
            if (expQ.size() == 0) timeoutFail("unexpected_start");
            else begin
               e = expQ.pop_front();
               check("tx_data", txData, e.d);
               check("grant_id", grantId, e.g);
               check("locked", locked, e.lk);
            end
         end
         accPrev = |(reqValid & reqReady);
         startPrev = txStart;
      end
   end

   // directed stimulus with hand-computed expectations
   initial begin
      int n;
      // reset held with ports 0..2 already valid
      sendByte(0, 1'b1, 8'h41);
      sendByte(1, 1'b1, 8'h42);
      sendByte(2, 1'b1, 8'h43);
      expectByte(2'd0, 8'h41, 1'b0);
      expectByte(2'd1, 8'h42, 1'b0);
      expectByte(2'd2, 8'h43, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check("ready_in_reset", reqReady, 4'b0000);
      end
      check("rst_tx_data", txData, 8'h00);
      check("rst_grant_id", grantId, 2'd3);
      check("rst_locked", locked, 1'b0);
      check("rst_tx_start", txStart, 1'b0);
      @(posedge clk);
      #2 rst = 1'b0;
      drain();
      // all four ports continuously valid after a fresh reset
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < 4; p++) begin
            sendByte(p, 1'b1, 8'(8'hA0 + 4 * r + p));
            expectByte(2'(p), 8'(8'hA0 + 4 * r + p), 1'b0);
         end
      drain();
      // locked packet on port 1 while port 2 waits
      sendByte(1, 1'b0, 8'hB1);
      sendByte(1, 1'b0, 8'hB2);
      sendByte(1, 1'b1, 8'hB3);
      sendByte(2, 1'b1, 8'hC1);
      expectByte(2'd1, 8'hB1, 1'b1);
      expectByte(2'd1, 8'hB2, 1'b1);
      expectByte(2'd1, 8'hB3, 1'b0);
      expectByte(2'd2, 8'hC1, 1'b0);
      drain();
      // lock timeout: port 3 opens a packet and goes quiet, port 0 waits
      sendByte(3, 1'b0, 8'hD3);
      expectByte(2'd3, 8'hD3, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!locked && n < 50);
      if (!locked) timeoutFail("lock_set");
      sendByte(0, 1'b1, 8'hD0);
      expectByte(2'd0, 8'hD0, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (txBusy && n < 50);
      if (txBusy) timeoutFail("busy_fall");
      check("lock_at_busy_fall", locked, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("lock_held", {locked, reqReady}, 5'b10000);
      end
      @(negedge clk);
      check("lock_released", {locked, reqReady}, 5'b00001);
      drain();
      // port valid in the same cycle tx_busy falls
      sendByte(1, 1'b1, 8'hE1);
      expectByte(2'd1, 8'hE1, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(busyCnt == 4'd1 && !txStart) && n < 50);
      if (n >= 50) timeoutFail("busy_last_cycle");
      sendByte(2, 1'b1, 8'hE2);
      expectByte(2'd2, 8'hE2, 1'b0);
      @(negedge clk);
      check("fall_cycle", {txBusy, reqValid[2], reqReady}, 6'b010000);
      @(negedge clk);
      check("accept_after_fall", reqReady, 4'b0100);
      @(negedge clk);
      check("start_two_after_fall", txStart, 1'b1);
      drain();
      // reset during WAIT while the transmitter is still busy
      sendByte(2, 1'b0, 8'hF2);
      expectByte(2'd2, 8'hF2, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!txStart && n < 50);
      if (!txStart) timeoutFail("start_before_reset");
      @(posedge clk);
      #2 rst = 1'b1;
      sendByte(3, 1'b1, 8'h93);
      sendByte(1, 1'b1, 8'h91);
      expectByte(2'd1, 8'h91, 1'b0);
      expectByte(2'd3, 8'h93, 1'b0);
      @(negedge clk);
      check("ready_in_mid_reset", reqReady, 4'b0000);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_tx_data", txData, 8'h00);
      check("mid_rst_grant_id", grantId, 2'd3);
      check("mid_rst_locked", locked, 1'b0);
      check("mid_rst_tx_start", txStart, 1'b0);
      n = 0;
      while (txBusy && n < 50) begin
         check("no_grant_while_busy", reqReady, 4'b0000);
         @(negedge clk);
         n++;
      end
      if (txBusy) timeoutFail("busy_after_reset");
      drain();
      check("queue_empty", expQ.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
